// File: rtl/sr_conv_sched.sv
// rtl/sr_conv_sched.sv - frame sequencer streaming feature/weight SRAM reads into the SR conv channel
module sr_conv_sched #(
    parameter int CH    = 64,
    parameter int K     = 8,
    parameter int OUT_W = 22,
    parameter int OUT_H = 22,
    parameter int DW    = 16,
    parameter int FAW   = 21,
    parameter int WAW   = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_i,
    input  logic           abort_i,
    input  logic [DW-1:0]  bias_cfg_i,
    output logic           busy_o,
    output logic           done_o,
    output logic           fm_rd_en_o,
    output logic [FAW-1:0] fm_addr_o,
    input  logic [DW-1:0]  fm_rdata_i,
    output logic           wt_rd_en_o,
    output logic [WAW-1:0] wt_addr_o,
    input  logic [DW-1:0]  wt_rdata_i,
    output logic           conv_rst_n_o,
    output logic           conv_in_valid_o,
    output logic [DW-1:0]  conv_in_data_o,
    output logic [DW-1:0]  conv_weight_o,
    output logic [DW-1:0]  conv_bias_o,
    input  logic           conv_out_valid_i,
    input  logic [DW-1:0]  conv_out_data_i,
    output logic           res_valid_o,
    output logic [DW-1:0]  res_data_o,
    output logic [7:0]     res_row_o,
    output logic [7:0]     res_col_o
);
    localparam int CHW  = (CH > 1) ? $clog2(CH) : 1;
    localparam int KW   = (K > 1) ? $clog2(K) : 1;
    localparam int OWW  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int OHW  = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int FCW  = (K * CH > 1) ? $clog2(K * CH) : 1;
    localparam int NRES = OUT_H * OUT_W;
    localparam int RCW  = $clog2(NRES + 1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ISSUE, S_FLUSH, S_DRAIN} state_t;

    state_t           state_q;
    logic [CHW-1:0]   ch_q;
    logic [KW-1:0]    kc_q, kr_q;
    logic [OWW-1:0]   oc_q;
    logic [OHW-1:0]   orow_q;
    logic [FCW-1:0]   fl_cnt_q;
    logic             clr_cnt_q, rd_en_q, flush_q, vld_d1_q, flush_d1_q;
    logic             conv_rst_n_q, done_q, res_valid_q;
    logic [DW-1:0]    bias_q, res_data_q;
    logic [7:0]       res_row_q, res_col_q, tag_row_q, tag_col_q;
    logic [RCW-1:0]   res_cnt_q;

    logic ch_max, kc_max, oc_max, kr_max, orow_max, in_frame, res_accept;

    assign ch_max   = (ch_q == CHW'(CH - 1));
    assign kc_max   = (kc_q == KW'(K - 1));
    assign oc_max   = (oc_q == OWW'(OUT_W - 1));
    assign kr_max   = (kr_q == KW'(K - 1));
    assign orow_max = (orow_q == OHW'(OUT_H - 1));

    // Results only count while a frame is in flight and until the frame is complete.
    assign in_frame   = (state_q == S_ISSUE) || (state_q == S_FLUSH) || (state_q == S_DRAIN);
    assign res_accept = conv_out_valid_i && in_frame && (res_cnt_q != RCW'(NRES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            {ch_q, kc_q, kr_q, oc_q, orow_q} <= '0;
            fl_cnt_q     <= '0;
            clr_cnt_q    <= 1'b0;
            rd_en_q      <= 1'b0;
            flush_q      <= 1'b0;
            vld_d1_q     <= 1'b0;
            flush_d1_q   <= 1'b0;
            conv_rst_n_q <= 1'b1;
            done_q       <= 1'b0;
            res_valid_q  <= 1'b0;
            bias_q       <= '0;
            res_data_q   <= '0;
            res_row_q    <= '0;
            res_col_q    <= '0;
            tag_row_q    <= '0;
            tag_col_q    <= '0;
            res_cnt_q    <= '0;
        end else begin
            done_q      <= 1'b0;
            vld_d1_q    <= rd_en_q | flush_q;
            flush_d1_q  <= flush_q;
            res_valid_q <= res_accept;
            if (clr_cnt_q) clr_cnt_q <= 1'b0;
            else           conv_rst_n_q <= 1'b1;

            if (res_accept) begin
                res_data_q <= conv_out_data_i;
                res_row_q  <= tag_row_q;
                res_col_q  <= tag_col_q;
                res_cnt_q  <= res_cnt_q + RCW'(1);
                if (tag_col_q == 8'(OUT_W - 1)) begin
                    tag_col_q <= '0;
                    tag_row_q <= tag_row_q + 8'd1;
                end else begin
                    tag_col_q <= tag_col_q + 8'd1;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (start_i && !abort_i) begin
                        state_q      <= S_CLEAR;
                        bias_q       <= bias_cfg_i;
                        conv_rst_n_q <= 1'b0;
                        clr_cnt_q    <= 1'b1;
                        res_cnt_q    <= '0;
                        tag_row_q    <= '0;
                        tag_col_q    <= '0;
                    end
                end
                S_CLEAR: begin
                    if (!clr_cnt_q) begin
                        state_q <= S_ISSUE;
                        rd_en_q <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (!ch_max) ch_q <= ch_q + CHW'(1);
                    else begin
                        ch_q <= '0;
                        if (!kc_max) kc_q <= kc_q + KW'(1);
                        else begin
                            kc_q <= '0;
                            if (!oc_max) oc_q <= oc_q + OWW'(1);
                            else begin
                                oc_q <= '0;
                                if (!kr_max) kr_q <= kr_q + KW'(1);
                                else begin
                                    kr_q <= '0;
                                    if (!orow_max) orow_q <= orow_q + OHW'(1);
                                    else begin
                                        orow_q   <= '0;
                                        state_q  <= S_FLUSH;
                                        rd_en_q  <= 1'b0;
                                        flush_q  <= 1'b1;
                                        fl_cnt_q <= '0;
                                    end
                                end
                            end
                        end
                    end
                end
                S_FLUSH: begin
                    fl_cnt_q <= fl_cnt_q + FCW'(1);
                    if (fl_cnt_q == FCW'(K * CH - 1)) begin
                        flush_q <= 1'b0;
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (res_cnt_q == RCW'(NRES)) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // Abort drops the in-flight element and re-resets the channel for two cycles.
            if (abort_i && (state_q != S_IDLE)) begin
                state_q      <= S_IDLE;
                rd_en_q      <= 1'b0;
                flush_q      <= 1'b0;
                vld_d1_q     <= 1'b0;
                flush_d1_q   <= 1'b0;
                conv_rst_n_q <= 1'b0;
                clr_cnt_q    <= 1'b1;
                done_q       <= 1'b0;
                {ch_q, kc_q, kr_q, oc_q, orow_q} <= '0;
            end
        end
    end

    assign busy_o          = (state_q != S_IDLE);
    assign done_o          = done_q;
    assign fm_rd_en_o      = rd_en_q;
    assign wt_rd_en_o      = rd_en_q;
    assign fm_addr_o       = FAW'(((32'(orow_q) * K + 32'(kr_q)) * (OUT_W * K)
                                   + 32'(oc_q) * K + 32'(kc_q)) * CH + 32'(ch_q));
    assign wt_addr_o       = WAW'((32'(kr_q) * K + 32'(kc_q)) * CH + 32'(ch_q));
    assign conv_rst_n_o    = conv_rst_n_q;
    assign conv_in_valid_o = vld_d1_q;
    assign conv_in_data_o  = flush_d1_q ? '0 : fm_rdata_i;
    assign conv_weight_o   = flush_d1_q ? '0 : wt_rdata_i;
    assign conv_bias_o     = bias_q;
    assign res_valid_o     = res_valid_q;
    assign res_data_o      = res_data_q;
    assign res_row_o       = res_row_q;
    assign res_col_o       = res_col_q;
endmodule
